// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S receive path (and the matching transmit
// path): receiver state encoding, channel codes and the default word width.
// ---------------------------------------------------------------------------
package i2s_pkg;

   // Bits per channel word on the I2S link, common to receive and transmit.
   localparam int I2S_DATA_W = 24;

   // Channel codes, equal to the lrclk level that selects the channel.
   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   // Receiver states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } i2s_state_e;

endpackage

// File: rtl/i2s_lrclk_edge.sv
// ---------------------------------------------------------------------------
// i2s_lrclk_edge
// Registers lrclk and flags a word-select transition. The register has no
// reset on purpose: it keeps following lrclk while the rest of the design is
// held in reset, so the first cycle after reset never sees a false edge.
//
// Ports:
//   sclk     in   serial bit clock (posedge)
//   lrclk    in   word select, 0 = left, 1 = right
//   lr_edge  out  high when lrclk differs from its registered copy
//   lr_chan  out  channel of the word that starts at this edge
// ---------------------------------------------------------------------------
module i2s_lrclk_edge (
   input  logic sclk,
   input  logic lrclk,
   output logic lr_edge,
   output logic lr_chan
);

   logic lr_d;
   logic lr_q;

   // Next value of the lrclk history register.
   always_comb begin
      lr_d = lrclk;
   end

   // lrclk history register, free running (also during reset).
   always_ff @(posedge sclk) begin
      lr_q <= lr_d;
   end

   // Edge and channel decode.
   always_comb begin
      lr_edge = (lrclk != lr_q);
      lr_chan = lrclk;
   end

endmodule

// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
// Deserialises an I2S stream into left/right parallel words. Each word is
// framed by an lrclk transition; the MSB is sampled DELAY posedges after the
// posedge that detects the transition and DATA_W bits are shifted in MSB
// first. Bits beyond DATA_W in a slot are ignored. A word cut short by an
// early lrclk transition is dropped and reported on short_err.
//
// Ports:
//   sclk         in   serial bit clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   lrclk        in   word select, 0 = left, 1 = right
//   sdin         in   serial data
//   left_data    out  last completed left word (held)
//   right_data   out  last completed right word (held)
//   left_valid   out  one-cycle pulse when left_data updates
//   right_valid  out  one-cycle pulse when right_data updates
//   frame_valid  out  pulse with right_valid when a left word preceded it
//   short_err    out  one-cycle pulse when a word is truncated
//
// DATA_W must be at least 2; DELAY must be in 1..4.
// ---------------------------------------------------------------------------
module i2s_receiver
   import i2s_pkg::*;
#(
   parameter int DATA_W = I2S_DATA_W,
   parameter int DELAY  = 1
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              lrclk,
   input  logic              sdin,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              left_valid,
   output logic              right_valid,
   output logic              frame_valid,
   output logic              short_err
);

   localparam int         CNT_W     = $clog2(DATA_W + 1);
   localparam logic [1:0] S_IDLE    = ST_IDLE;
   localparam logic [1:0] S_WAIT    = ST_WAIT;
   localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
   localparam logic [1:0] S_HOLD    = ST_HOLD;
   localparam logic [1:0] DLY_LOAD  = 2'(DELAY - 1);

   logic              lr_edge;
   logic              lr_chan;

   logic [1:0]        state_q,       state_d;
   logic [1:0]        dly_q,         dly_d;
   logic [CNT_W-1:0]  bit_cnt_q,     bit_cnt_d;
   logic [DATA_W-1:0] shift_q,       shift_d;
   logic              chan_q,        chan_d;
   logic              left_seen_q,   left_seen_d;
   logic [DATA_W-1:0] left_data_q,   left_data_d;
   logic [DATA_W-1:0] right_data_q,  right_data_d;
   logic              left_valid_q,  left_valid_d;
   logic              right_valid_q, right_valid_d;
   logic              frame_valid_q, frame_valid_d;
   logic              short_err_q,   short_err_d;

   logic              sample_s;
   logic              last_s;
   logic              restart_s;
   logic [CNT_W-1:0]  cnt_next_s;
   logic [DATA_W-1:0] word_s;

   i2s_lrclk_edge u_lrclk_edge (
      .sclk    (sclk),
      .lrclk   (lrclk),
      .lr_edge (lr_edge),
      .lr_chan (lr_chan)
   );

   // Bit sampling. The posedge on which the WAIT countdown sits at zero is
   // itself the MSB sample, so the MSB lands DELAY posedges after the edge.
   always_comb begin
      sample_s   = 1'b0;
      cnt_next_s = bit_cnt_q;
      word_s     = shift_q;
      if ((state_q == S_WAIT) && (dly_q == 2'd0)) begin
         sample_s   = 1'b1;
         cnt_next_s = CNT_W'(1);
         word_s     = {{(DATA_W-1){1'b0}}, sdin};
      end else if (state_q == S_CAPTURE) begin
         sample_s   = 1'b1;
         cnt_next_s = bit_cnt_q + CNT_W'(1);
         word_s     = {shift_q[DATA_W-2:0], sdin};
      end else begin
         sample_s   = 1'b0;
      end
      last_s = sample_s && (cnt_next_s == CNT_W'(DATA_W));
   end

   // Next-state, commit and pulse logic.
   always_comb begin
      state_d       = state_q;
      dly_d         = dly_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      chan_d        = chan_q;
      left_seen_d   = left_seen_q;
      left_data_d   = left_data_q;
      right_data_d  = right_data_q;
      left_valid_d  = 1'b0;
      right_valid_d = 1'b0;
      frame_valid_d = 1'b0;
      short_err_d   = 1'b0;
      restart_s     = 1'b0;

      // Commit a completed word. This happens even when an edge arrives on
      // the final bit; the new word is then started below.
      if (last_s) begin
         if (chan_q == CH_LEFT) begin
            left_data_d  = word_s;
            left_valid_d = 1'b1;
            left_seen_d  = 1'b1;
         end else begin
            right_data_d  = word_s;
            right_valid_d = 1'b1;
            if (left_seen_q) begin
               frame_valid_d = 1'b1;
               left_seen_d   = 1'b0;
            end else begin
               frame_valid_d = 1'b0;
            end
         end
      end else begin
         left_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (lr_edge) begin
               restart_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (lr_edge) begin
               restart_s   = 1'b1;
               short_err_d = 1'b1;
            end else if (dly_q == 2'd0) begin
               shift_d   = word_s;
               bit_cnt_d = cnt_next_s;
               state_d   = S_CAPTURE;
            end else begin
               dly_d = dly_q - 2'd1;
            end
         end
         S_CAPTURE: begin
            if (last_s) begin
               shift_d   = word_s;
               bit_cnt_d = cnt_next_s;
               if (lr_edge) begin
                  restart_s = 1'b1;
               end else begin
                  state_d = S_HOLD;
               end
            end else if (lr_edge) begin
               // Truncated word: drop it and break any pending frame pairing.
               restart_s   = 1'b1;
               short_err_d = 1'b1;
               left_seen_d = 1'b0;
            end else begin
               shift_d   = word_s;
               bit_cnt_d = cnt_next_s;
            end
         end
         S_HOLD: begin
            if (lr_edge) begin
               restart_s = 1'b1;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Start a new word for the channel selected by the new lrclk level.
      if (restart_s) begin
         state_d   = S_WAIT;
         dly_d     = DLY_LOAD;
         bit_cnt_d = '0;
         shift_d   = '0;
         chan_d    = lr_chan;
      end else begin
         chan_d = chan_q;
      end
   end

   // State and output registers.
   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         dly_q         <= 2'd0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         chan_q        <= CH_LEFT;
         left_seen_q   <= 1'b0;
         left_data_q   <= '0;
         right_data_q  <= '0;
         left_valid_q  <= 1'b0;
         right_valid_q <= 1'b0;
         frame_valid_q <= 1'b0;
         short_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         dly_q         <= dly_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         chan_q        <= chan_d;
         left_seen_q   <= left_seen_d;
         left_data_q   <= left_data_d;
         right_data_q  <= right_data_d;
         left_valid_q  <= left_valid_d;
         right_valid_q <= right_valid_d;
         frame_valid_q <= frame_valid_d;
         short_err_q   <= short_err_d;
      end
   end

   // Output drive from registers.
   always_comb begin
      left_data   = left_data_q;
      right_data  = right_data_q;
      left_valid  = left_valid_q;
      right_valid = right_valid_q;
      frame_valid = frame_valid_q;
      short_err   = short_err_q;
   end

endmodule

// File: tb/tb_i2s_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_receiver
// Self-checking bench for i2s_receiver. Instance a uses DELAY = 1, instance
// b uses DELAY = 2. The word driver pushes the expected commit (channel,
// data, frame flag, cycle) onto a scoreboard; a negedge monitor pops and
// compares whenever a valid pulse appears.
// ---------------------------------------------------------------------------
module tb_i2s_receiver;
   import i2s_pkg::*;

   localparam int DW = 24;

   logic          sclk   = 1'b0;
   logic          rst    = 1'b1;
   logic          lrclk  = 1'b1;
   logic          sdin   = 1'b0;
   logic          lrclk2 = 1'b0;
   logic          sdin2  = 1'b0;

   logic [DW-1:0] left_data_a,  right_data_a;
   logic          left_valid_a, right_valid_a, frame_valid_a, short_err_a;
   logic [DW-1:0] left_data_b,  right_data_b;
   logic          left_valid_b, right_valid_b, frame_valid_b, short_err_b;

   typedef struct {
      int            inst;
      logic          ch;
      logic [DW-1:0] data;
      logic          frame;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   short_exp [2] = '{0, 0};
   int   short_obs [2] = '{0, 0};
   int   valid_obs [2] = '{0, 0};
   int   frame_obs [2] = '{0, 0};
   logic left_seen_m [2] = '{1'b0, 1'b0};

   i2s_receiver #(.DATA_W(DW), .DELAY(1)) dut_a (
      .sclk        (sclk),
      .rst         (rst),
      .lrclk       (lrclk),
      .sdin        (sdin),
      .left_data   (left_data_a),
      .right_data  (right_data_a),
      .left_valid  (left_valid_a),
      .right_valid (right_valid_a),
      .frame_valid (frame_valid_a),
      .short_err   (short_err_a)
   );

   i2s_receiver #(.DATA_W(DW), .DELAY(2)) dut_b (
      .sclk        (sclk),
      .rst         (rst),
      .lrclk       (lrclk2),
      .sdin        (sdin2),
      .left_data   (left_data_b),
      .right_data  (right_data_b),
      .left_valid  (left_valid_b),
      .right_valid (right_valid_b),
      .frame_valid (frame_valid_b),
      .short_err   (short_err_b)
   );

   // Bit clock.
   always #5 sclk = ~sclk;

   // Posedge counter used to time expected pulses.
   always @(posedge sclk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic mon(input int inst, input logic lv, input logic rv, input logic fv,
                      input logic se, input logic [DW-1:0] ld, input logic [DW-1:0] rd);
      exp_t e;
      if (se) short_obs[inst]++;
      if (lv) valid_obs[inst]++;
      if (rv) valid_obs[inst]++;
      if (fv) frame_obs[inst]++;
      if (lv || rv) begin
         if (sb.size() == 0) begin
            check_val("unexpected_valid", {30'd0, lv, rv}, 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("inst", inst, e.inst);
            check_val("cycle", cyc, e.cyc);
            check_val("left_valid", {31'd0, lv}, {31'd0, e.ch == CH_LEFT});
            check_val("right_valid", {31'd0, rv}, {31'd0, e.ch == CH_RIGHT});
            check_val("frame_valid", {31'd0, fv}, {31'd0, e.frame});
            check_val("data", (e.ch == CH_LEFT) ? ld : rd, e.data);
         end
      end else if (fv) begin
         check_val("frame_without_right", {31'd0, fv}, 32'd0);
      end
   endtask

   // Output monitor, away from the active edge.
   always @(negedge sclk) begin
      mon(0, left_valid_a, right_valid_a, frame_valid_a, short_err_a, left_data_a, right_data_a);
      mon(1, left_valid_b, right_valid_b, frame_valid_b, short_err_b, left_data_b, right_data_b);
   end

   // Drive one slot: lrclk level ch for 'slot' cycles, word MSB first starting
   // DELAY cycles after the edge. nbits < DW describes a truncated word.
   // Must be entered 1 time unit after a posedge.
   task automatic send_word(input int inst, input logic ch, input logic [DW-1:0] data,
                            input int nbits, input int slot);
      int   dly;
      exp_t e;
      logic b;
      dly = (inst == 0) ? 1 : 2;
      if (nbits >= DW) begin
         e.inst = inst;
         e.ch   = ch;
         e.data = data;
         e.cyc  = cyc + 1 + dly + DW - 1;
         if (ch == CH_LEFT) begin
            e.frame           = 1'b0;
            left_seen_m[inst] = 1'b1;
         end else begin
            e.frame           = left_seen_m[inst];
            left_seen_m[inst] = 1'b0;
         end
         sb.push_back(e);
      end else begin
         short_exp[inst]++;
         left_seen_m[inst] = 1'b0;
      end
      for (int c = 0; c < slot; c++) begin
         if (c < dly) b = 1'b0;
         else if (c - dly < DW) b = data[DW-1-(c-dly)];
         else b = 1'($urandom);
         if (inst == 0) begin
            lrclk = ch;
            sdin  = b;
         end else begin
            lrclk2 = ch;
            sdin2  = b;
         end
         @(posedge sclk);
         #1;
      end
   endtask

   // Safety net against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Stimulus sequence.
   initial begin
      int            v0, f0, s0;
      logic [DW-1:0] part;
      logic [DW-1:0] rnd;
      part = 24'hC3C3C3;

      // Reset
      rst = 1'b1;
      repeat (3) @(posedge sclk);
      #1;
      check_val("rst_left_data", left_data_a, 32'd0);
      check_val("rst_right_data", right_data_a, 32'd0);
      check_val("rst_pulses", {28'd0, left_valid_a, right_valid_a, frame_valid_a, short_err_a}, 32'd0);
      check_val("rst_state", {30'd0, dut_a.state_q}, 32'd0);
      rst = 1'b0;
      @(posedge sclk);
      #1;
      check_val("post_rst_no_edge", {30'd0, dut_a.state_q}, 32'd0);

      // Single left word, then a right word completing the frame
      send_word(0, CH_LEFT, 24'hA5F00F, 24, 32);
      check_val("t1_left_data", left_data_a, 32'hA5F00F);
      check_val("t1_no_short", short_obs[0], 32'd0);
      send_word(0, CH_RIGHT, 24'h5A5A5A, 24, 32);

      // Full frame in 32-bit slots, trailing bits random
      send_word(0, CH_LEFT, 24'h123456, 24, 32);
      send_word(0, CH_RIGHT, 24'h800001, 24, 32);
      check_val("t2_left_held", left_data_a, 32'h123456);
      check_val("t2_right_held", right_data_a, 32'h800001);

      // Truncated left word, then right word without frame
      send_word(0, CH_LEFT, 24'hFFFFFF, 10, 11);
      send_word(0, CH_RIGHT, 24'h00FFFF, 24, 32);
      check_val("t3_short_count", short_obs[0], short_exp[0]);
      check_val("t3_left_unchanged", left_data_a, 32'h123456);
      check_val("t3_right_data", right_data_a, 32'h00FFFF);

      // Reset in the middle of a left word (12 bits sampled)
      for (int c = 0; c < 13; c++) begin
         lrclk = CH_LEFT;
         sdin  = (c == 0) ? 1'b0 : part[DW-c];
         @(posedge sclk);
         #1;
      end
      rst = 1'b1;
      @(posedge sclk);
      #1;
      rst = 1'b0;
      left_seen_m[0] = 1'b0;
      left_seen_m[1] = 1'b0;
      check_val("mid_rst_left_data", left_data_a, 32'd0);
      check_val("mid_rst_right_data", right_data_a, 32'd0);
      check_val("mid_rst_pulses", {28'd0, left_valid_a, right_valid_a, frame_valid_a, short_err_a}, 32'd0);
      check_val("mid_rst_state", {30'd0, dut_a.state_q}, 32'd0);
      for (int c = 0; c < 12; c++) begin
         sdin = 1'($urandom);
         @(posedge sclk);
         #1;
      end
      check_val("mid_rst_ignored", left_data_a, 32'd0);
      send_word(0, CH_RIGHT, 24'h13579B, 24, 32);
      send_word(0, CH_LEFT, 24'h2468AC, 24, 32);
      send_word(0, CH_RIGHT, 24'hDEAD01, 24, 32);
      check_val("post_rst_left", left_data_a, 32'h2468AC);
      check_val("post_rst_right", right_data_a, 32'hDEAD01);

      // Minimum spacing: eight words DELAY+DATA_W cycles apart
      v0 = valid_obs[0];
      f0 = frame_obs[0];
      s0 = short_obs[0];
      for (int k = 0; k < 8; k++) begin
         rnd = DW'($urandom);
         send_word(0, (k % 2 == 0) ? CH_LEFT : CH_RIGHT, rnd, 24, 25);
      end
      repeat (2) @(posedge sclk);
      #1;
      check_val("min_valid_count", valid_obs[0] - v0, 32'd8);
      check_val("min_frame_count", frame_obs[0] - f0, 32'd4);
      check_val("min_short_count", short_obs[0] - s0, 32'd0);

      // DELAY = 2: MSB must come from edge+2, edge+1 carries a zero
      send_word(1, CH_RIGHT, 24'hFFFFFF, 24, 30);
      check_val("d2_right_data", right_data_b, 32'hFFFFFF);
      check_val("d2_left_data", left_data_b, 32'd0);
      send_word(1, CH_LEFT, 24'h0F1E2D, 24, 30);
      send_word(1, CH_RIGHT, 24'h3C4B5A, 24, 30);
      check_val("d2_frame_count", frame_obs[1], 32'd1);

      // Drain and final accounting
      repeat (4) @(posedge sclk);
      #1;
      check_val("sb_empty", sb.size(), 32'd0);
      check_val("short_total_a", short_obs[0], short_exp[0]);
      check_val("short_total_b", short_obs[1], short_exp[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
